// File: rtl/rv_imem_server.sv
// Instruction-memory server: single-port word RAM with a back-door loader,
// programmable fetch latency and NOP substitution for bad fetch addresses.
module rv_imem_server #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  output logic        im_err_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  logic [31:0] mem [DEPTH];

  state_t      fsm_q, fsm_d;
  logic [31:0] a_q, a_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ld_q;
  logic        valid_q, err_q;
  logic [31:0] data_q;

  logic        new_fetch;
  logic        rd_en;
  logic        im_bad;
  logic        ld_ok;

  assign im_bad = (im_addr_i[1:0] != 2'b00) || ((im_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
  assign ld_ok  = (ld_addr_i[1:0] == 2'b00) && ((ld_addr_i >> (ADDR_WIDTH + 2)) == 32'd0);

  // A write in the previous cycle invalidates whatever fetch was in flight.
  assign new_fetch = (fsm_q == IDLE) || (im_addr_i != a_q) || ld_q;

  always_comb begin
    fsm_d = fsm_q;
    a_d   = a_q;
    cnt_d = cnt_q;
    rd_en = 1'b0;
    if (ld_we_i) begin
      fsm_d = IDLE;
    end else if (new_fetch) begin
      a_d   = im_addr_i;
      cnt_d = WS;
      if (WS == 4'd0) begin
        fsm_d = READY;
        rd_en = 1'b1;
      end else begin
        fsm_d = WAIT;
      end
    end else if (fsm_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        fsm_d = READY;
        rd_en = 1'b1;
      end
    end else begin
      rd_en = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fsm_q   <= IDLE;
      a_q     <= 32'd0;
      cnt_q   <= 4'd0;
      ld_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      fsm_q   <= fsm_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_we_i;
      valid_q <= rd_en;
      err_q   <= rd_en && im_bad;
      if (rd_en) begin
        data_q <= im_bad ? NOP : mem[im_addr_i[ADDR_WIDTH+1:2]];
      end
    end
  end

  // RAM contents survive reset; only the loader port writes them.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && ld_we_i && ld_ok) begin
      mem[ld_addr_i[ADDR_WIDTH+1:2]] <= ld_data_i;
    end
  end

  assign im_data_o  = data_q;
  assign im_valid_o = valid_q;
  assign im_err_o   = err_q;

endmodule

// File: tb/tb_rv_imem_server.sv
// Directed bench: a zero-wait-state and a two-wait-state server share stimulus.
module tb_rv_imem_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;

  logic [31:0] d0, d2;
  logic        v0, v2, e0, e2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_imem_server #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr),
    .im_data_o(d0), .im_valid_o(v0), .im_err_o(e0),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  rv_imem_server #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr),
    .im_data_o(d2), .im_valid_o(v2), .im_err_o(e2),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] addr;
    logic        exp_v;
    logic        exp_e;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Apply inputs, clock once, then look at the registered outputs.
  task automatic cyc(input logic r, input logic w, input logic [31:0] la,
                     input logic [31:0] ld, input logic [31:0] a);
    rst_n   = r;
    ld_we   = w;
    ld_addr = la;
    ld_data = ld;
    im_addr = a;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] la,
                              input logic [31:0] ld, input logic [31:0] a,
                              input logic ev, input logic ee, input logic [31:0] ed);
    vec_t v;
    v.rst_n = r; v.we = w; v.ld_addr = la; v.ld_data = ld; v.addr = a;
    v.exp_v = ev; v.exp_e = ee; v.exp_d = ed;
    return v;
  endfunction

  initial begin
    // Zero-wait-state sequence: load, drop bad writes, stream, errors, RAW.
    vecs[0]  = mk(1, 1, 32'h0,    32'h11,   32'h0,    0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 32'h4,    32'h22,   32'h0,    0, 0, 32'h0);
    vecs[2]  = mk(1, 1, 32'h8,    32'h33,   32'h0,    0, 0, 32'h0);
    vecs[3]  = mk(1, 1, 32'hC,    32'h44,   32'h0,    0, 0, 32'h0);
    vecs[4]  = mk(1, 1, 32'h14,   32'h55,   32'h0,    0, 0, 32'h0);
    vecs[5]  = mk(1, 1, 32'h1000, 32'h99,   32'h0,    0, 0, 32'h0);
    vecs[6]  = mk(1, 1, 32'h2,    32'h77,   32'h0,    0, 0, 32'h0);
    vecs[7]  = mk(1, 0, 32'h0,    32'h0,    32'h0,    1, 0, 32'h11);
    vecs[8]  = mk(1, 0, 32'h0,    32'h0,    32'h4,    1, 0, 32'h22);
    vecs[9]  = mk(1, 0, 32'h0,    32'h0,    32'h8,    1, 0, 32'h33);
    vecs[10] = mk(1, 0, 32'h0,    32'h0,    32'hC,    1, 0, 32'h44);
    vecs[11] = mk(1, 0, 32'h0,    32'h0,    32'hC,    1, 0, 32'h44);
    vecs[12] = mk(1, 0, 32'h0,    32'h0,    32'h6,    1, 1, 32'h13);
    vecs[13] = mk(1, 0, 32'h0,    32'h0,    32'h1000, 1, 1, 32'h13);
    vecs[14] = mk(1, 0, 32'h0,    32'h0,    32'h4,    1, 0, 32'h22);
    vecs[15] = mk(1, 1, 32'h4,    32'hDEAD, 32'h4,    0, 0, 32'h22);
    vecs[16] = mk(1, 0, 32'h0,    32'h0,    32'h4,    1, 0, 32'hDEAD);
    vecs[17] = mk(1, 0, 32'h0,    32'h0,    32'h4,    1, 0, 32'hDEAD);

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_valid0", {31'd0, v0}, 32'd0);
    chk("reset_err0",   {31'd0, e0}, 32'd0);
    chk("reset_data0",  d0, 32'd0);
    chk("reset_valid2", {31'd0, v2}, 32'd0);
    chk("reset_data2",  d2, 32'd0);

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].rst_n, vecs[i].we, vecs[i].ld_addr, vecs[i].ld_data, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, v0}, {31'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d_err", i),   {31'd0, e0}, {31'd0, vecs[i].exp_e});
      chk($sformatf("vec%0d_data", i),  d0, vecs[i].exp_d);
    end

    // Two wait states, address 8 held for five cycles.
    begin
      logic [4:0] exp_v = 5'b00111;
      for (int i = 0; i < 5; i++) begin
        cyc(1, 0, 0, 0, 32'h8);
        chk($sformatf("hold8_c%0d_valid", i), {31'd0, v2}, {31'd0, exp_v[4-i]});
        if (exp_v[4-i]) chk($sformatf("hold8_c%0d_data", i), d2, 32'h33);
      end
    end

    // Address 4 for two cycles aborted by a switch to 12.
    begin
      logic [31:0] seq_a [5];
      logic [4:0]  exp_v = 5'b00001;
      seq_a[0] = 32'h4; seq_a[1] = 32'h4; seq_a[2] = 32'hC; seq_a[3] = 32'hC; seq_a[4] = 32'hC;
      for (int i = 0; i < 5; i++) begin
        cyc(1, 0, 0, 0, seq_a[i]);
        chk($sformatf("abort_c%0d_valid", i), {31'd0, v2}, {31'd0, exp_v[4-i]});
        chk($sformatf("abort_c%0d_data", i), d2, exp_v[4-i] ? 32'h44 : 32'h33);
      end
    end

    // Reset in the first wait cycle; a loader write during reset is ignored.
    cyc(1, 0, 0, 0, 32'h0);
    chk("rstwait_start_valid", {31'd0, v2}, 32'd0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("rstwait_in_reset_valid", {31'd0, v2}, 32'd0);
    cyc(0, 1, 32'h14, 32'hBAD, 32'h0);
    chk("rstwait_in_reset_data", d2, 32'd0);
    cyc(1, 0, 0, 0, 32'h0);
    chk("rstwait_rel_c0_valid", {31'd0, v2}, 32'd0);
    chk("rstwait_rel_u0_data", d0, 32'h11);
    cyc(1, 0, 0, 0, 32'h0);
    chk("rstwait_rel_c1_valid", {31'd0, v2}, 32'd0);
    cyc(1, 0, 0, 0, 32'h0);
    chk("rstwait_rel_c2_valid", {31'd0, v2}, 32'd1);
    chk("rstwait_rel_c2_data", d2, 32'h11);

    // Word 5 keeps its pre-reset contents.
    cyc(1, 0, 0, 0, 32'h14);
    chk("ram_kept_u0_valid", {31'd0, v0}, 32'd1);
    chk("ram_kept_u0_data", d0, 32'h55);
    cyc(1, 0, 0, 0, 32'h14);
    cyc(1, 0, 0, 0, 32'h14);
    chk("ram_kept_u2_valid", {31'd0, v2}, 32'd1);
    chk("ram_kept_u2_data", d2, 32'h55);
    chk("ram_kept_u2_err", {31'd0, e2}, 32'd0);

    // Misaligned fetch with wait states: normal timing, NOP and error.
    cyc(1, 0, 0, 0, 32'h6);
    chk("mis2_c0_valid", {31'd0, v2}, 32'd0);
    chk("mis2_c0_err", {31'd0, e2}, 32'd0);
    cyc(1, 0, 0, 0, 32'h6);
    chk("mis2_c1_valid", {31'd0, v2}, 32'd0);
    cyc(1, 0, 0, 0, 32'h6);
    chk("mis2_c2_valid", {31'd0, v2}, 32'd1);
    chk("mis2_c2_err", {31'd0, e2}, 32'd1);
    chk("mis2_c2_data", d2, 32'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_imem_server.md
RV_IMEM_SERVER -- requirements
Module: rv_imem_server

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits of internal instruction RAM (2^ADDR_WIDTH words of 32 bits).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before each new fetch completes (range 0..15).
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port im_addr_i  input  32  fetch byte address from core, sampled every cycle.
REQ-006 SHALL have port im_data_o  output  32  instruction word, registered.
REQ-007 SHALL have port im_valid_o  output  1  im_data_o holds a completed fetch, registered.
REQ-008 SHALL have port im_err_o  output  1  completed fetch was misaligned or out of range, registered.
REQ-009 SHALL have port ld_we_i  input  1  loader write strobe, one word per cycle.
REQ-010 SHALL have port ld_addr_i  input  32  loader byte address.
REQ-011 SHALL have port ld_data_i  input  32  loader write data.

Function
REQ-012 SHALL hold state a_q (last sampled im_addr_i), cnt (4-bit wait counter), fsm in {IDLE, WAIT, READY}.
REQ-013 SHALL treat a fetch as "new" in a cycle when fsm=IDLE, or im_addr_i != a_q, or ld_we_i=1 in the previous cycle.
REQ-014 On a new fetch SHALL load a_q<=im_addr_i, cnt<=WAIT_STATES; fsm->READY if WAIT_STATES=0, else fsm->WAIT.
REQ-015 In WAIT with same address SHALL decrement cnt; fsm->READY in the cycle cnt is sampled as 1.
REQ-016 SHALL drive im_valid_o=1 in cycle t+1 iff fsm enters/remains READY in cycle t with no ld_we_i in cycle t; otherwise im_valid_o=0.
REQ-017 WAIT_STATES=0: address A in cycle t SHALL yield im_data_o=mem[A[ADDR_WIDTH+1:2]], im_valid_o=1 in t+1; a new address every cycle SHALL give valid every cycle (full throughput).
REQ-018 WAIT_STATES=N>0: address A held for N+1 consecutive cycles SHALL yield valid on cycle N+1 after first presentation; valid SHALL remain 1 while A is held.
REQ-019 Address change during WAIT SHALL abort the pending fetch and restart counting for the new address; no valid for the aborted address.
REQ-020 Misaligned (im_addr_i[1:0]!=0) or out-of-range (im_addr_i[31:ADDR_WIDTH+2]!=0) fetch SHALL complete with normal timing, im_data_o=32'h00000013 (NOP), im_err_o=1; im_err_o=0 on every in-range aligned completion and whenever im_valid_o=0.
REQ-021 ld_we_i=1 SHALL write ld_data_i to mem[ld_addr_i[ADDR_WIDTH+1:2]] at the edge; out-of-range or misaligned loader writes SHALL be dropped silently.
REQ-022 Loader write SHALL take priority over fetch (single-port RAM): im_valid_o=0 next cycle, and the current fetch restarts per REQ-013 after the write.
REQ-023 Read-after-write of the same word SHALL return the new data on the first completion after the write.
REQ-024 im_data_o SHALL hold its last value while im_valid_o=0.

Reset
REQ-025 With rst_n_i=0 at a rising edge SHALL set im_valid_o=0, im_err_o=0, im_data_o=0, a_q=0, cnt=0, fsm=IDLE.
REQ-026 RAM contents SHALL NOT be cleared by reset.
REQ-027 Reset mid-WAIT SHALL abort the fetch; first cycle after release SHALL be treated as a new fetch.
REQ-028 Loader writes with rst_n_i=0 SHALL be ignored.

Verification
REQ-029 WAIT_STATES=0, load mem[0..3]=0x11,0x22,0x33,0x44, present 0,4,8,12 on consecutive cycles -> im_valid_o=1 on 4 following cycles, data 0x11,0x22,0x33,0x44.
REQ-030 WAIT_STATES=2, hold address 8 for 5 cycles -> im_valid_o 0,0,1,1,1 with im_data_o=0x33 when valid.
REQ-031 WAIT_STATES=2, address 4 for 2 cycles then 12 held -> no valid for 4; valid 3 cycles after switch with 0x44.
REQ-032 Address 0x00000006 and address 4<<ADDR_WIDTH -> im_valid_o=1, im_err_o=1, im_data_o=0x00000013.
REQ-033 Fetch address 4 streaming, ld_we_i writes 0xDEAD to address 4 -> im_valid_o=0 the cycle after the write, next completion returns 0xDEAD.
REQ-034 Assert rst_n_i=0 during WAIT cycle 1 of 3 -> im_valid_o=0 through reset; after release full WAIT_STATES+1 cycles elapse before valid.
